// File: rtl/iso_bus_pipe.sv
// iso_bus_pipe: N-stage registered valid/ready bus pipeline where each stage
// lives in its own switchable power domain. A stage asked to isolate first
// drains its held word downstream, then clamps; on release it spends one
// WAKE cycle clearing its register before it accepts traffic again.
module iso_bus_pipe #(
  parameter int                WIDTH     = 8,
  parameter int                NSTAGES   = 3,
  parameter logic [WIDTH-1:0]  ISO_CLAMP = '0
) (
  input  logic               ck,
  input  logic               arst,
  input  logic               in_start,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_rdy,
  output logic               out_exec,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_rdy,
  input  logic [NSTAGES-1:0] iso_req,
  output logic [NSTAGES-1:0] iso_ack
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISO   = 2'd2,
    ST_WAKE  = 2'd3
  } stage_state_t;

  // Per-stage views collected from the generate blocks below.
  logic [NSTAGES-1:0] valid_reg;          // stage holds a word
  logic [NSTAGES-1:0] ack_reg;            // stage clamp active
  logic [NSTAGES-1:0] run;                // stage is in RUN and may accept
  logic [NSTAGES-1:0] vis;                // word visible past the clamp
  logic [NSTAGES-1:0] take;               // word leaves the stage this cycle
  logic [NSTAGES:0]   rdy;                // rdy[i]: stage i accepts; rdy[NSTAGES] = sink
  logic [WIDTH-1:0]   d_vis [NSTAGES];    // data seen downstream of each stage

  // Ready ripples back from the sink; a full stage is ready only if it empties this cycle.
  always_comb begin
    rdy          = '0;
    take         = '0;
    rdy[NSTAGES] = out_rdy;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      take[i] = vis[i] && rdy[i+1];
      rdy[i]  = run[i] && (!valid_reg[i] || take[i]);
    end
  end

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    stage_state_t     st_reg;
    logic             v_reg;
    logic             a_reg;
    logic [WIDTH-1:0] d_reg;
    logic             vin;
    logic [WIDTH-1:0] din;

    if (gi == 0) begin : g_head
      assign vin = in_start;
      assign din = in_data;
    end else begin : g_body
      assign vin = vis[gi-1];
      assign din = d_vis[gi-1];
    end

    // Drain-then-isolate handshake; the ack register rises with entry into ISO
    // and falls when WAKE hands the stage back to RUN.
    always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
        st_reg <= ST_RUN;
        a_reg  <= 1'b0;
      end else begin
        case (st_reg)
          ST_RUN: begin
            if (iso_req[gi]) st_reg <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (!iso_req[gi]) begin
              st_reg <= ST_RUN;
            end else if (!v_reg || take[gi]) begin
              st_reg <= ST_ISO;
              a_reg  <= 1'b1;
            end
          end
          ST_ISO: begin
            if (!iso_req[gi]) st_reg <= ST_WAKE;
          end
          ST_WAKE: begin
            st_reg <= ST_RUN;
            a_reg  <= 1'b0;
          end
          default: begin
            st_reg <= ST_RUN;
            a_reg  <= 1'b0;
          end
        endcase
      end
    end

    // Word register: cleared while waking (its content is untrusted after power-up),
    // loaded on accept, emptied when the word moves downstream.
    always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
        v_reg <= 1'b0;
        d_reg <= ISO_CLAMP;
      end else if (st_reg == ST_WAKE) begin
        v_reg <= 1'b0;
        d_reg <= ISO_CLAMP;
      end else if (vin && rdy[gi]) begin
        v_reg <= 1'b1;
        d_reg <= din;
      end else if (take[gi]) begin
        v_reg <= 1'b0;
      end
    end

    assign valid_reg[gi] = v_reg;
    assign ack_reg[gi]   = a_reg;
    assign run[gi]       = (st_reg == ST_RUN);
    assign vis[gi]       = v_reg && !a_reg;
    assign d_vis[gi]     = a_reg ? ISO_CLAMP : d_reg;
  end

  assign in_rdy   = rdy[0];
  assign out_exec = vis[NSTAGES-1];
  assign out_data = d_vis[NSTAGES-1];
  assign iso_ack  = ack_reg;

endmodule
